instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port imem_req_valid, output, 1, fetch request pending.
REQ-005 The module SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-006 The module SHALL have port imem_addr, output, 32, fetch address, equal to the PC.
REQ-007 The module SHALL have port imem_rsp_valid, input, 1, instruction word returned.
REQ-008 The module SHALL have port imem_rsp_data, input, 32, returned instruction word.
REQ-009 The module SHALL have port instr, output, 32, instruction presented to decode.
REQ-010 The module SHALL have port instr_pc, output, 32, PC of instr.
REQ-011 The module SHALL have port instr_valid, output, 1, instr/instr_pc valid.
REQ-012 The module SHALL have port instr_ready, input, 1, decode accepts instr.
REQ-013 The module SHALL have port resolve_valid, input, 1, execute has resolved the issued instruction.
REQ-014 The module SHALL have port branch_op, input, 2, 00 never, 01 taken-if-ALU-non-zero, 10 taken-if-ALU-zero, 11 always.
REQ-015 The module SHALL have port alu_zero, input, 1, ALU result-is-zero flag.
REQ-016 The module SHALL have port branch_target, input, 32, base+offset sum from the ALU.
REQ-017 The module SHALL have port misalign_err, output, 1, sticky taken-target-misaligned flag.
REQ-018 The module SHALL have port retire_count, output, 32, count of resolved instructions.

Function
REQ-019 The FSM SHALL have states FETCH, WAIT, HOLD, RESOLVE, HALT.
REQ-020 In FETCH, imem_req_valid=1; on imem_req_valid&imem_req_ready the FSM SHALL go to WAIT; imem_addr SHALL be stable while the request is unaccepted.
REQ-021 In WAIT, on imem_rsp_valid the FSM SHALL capture imem_rsp_data into instr and the PC into instr_pc, then go to HOLD; imem_rsp_valid in any other state SHALL be ignored.
REQ-022 In HOLD, instr_valid=1; on instr_ready the FSM SHALL go to RESOLVE; instr/instr_pc SHALL be stable while in HOLD.
REQ-023 In RESOLVE, on resolve_valid: taken = (op==11) | (op==10 & alu_zero) | (op==01 & ~alu_zero).
REQ-024 In RESOLVE, on resolve_valid, next PC SHALL be {branch_target[31:1],1'b0} if taken, else PC+4 modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-025 In RESOLVE, on resolve_valid, retire_count SHALL increment by 1 (wrapping at 2^32); resolve_valid outside RESOLVE SHALL be ignored.
REQ-026 If taken and branch_target[1]=1, the FSM SHALL set misalign_err, leave the PC unchanged, and go to HALT; otherwise it SHALL load the next PC and go to FETCH.
REQ-027 HALT SHALL be left only by reset; all valid outputs SHALL stay 0 there.
REQ-028 Minimum loop latency SHALL be: request accepted cycle T, response at T+1, instr_valid at T+2, resolve at T+3, next imem_req_valid at T+4.
REQ-029 imem_req_valid and instr_valid SHALL be registered outputs, never combinationally dependent on inputs.

Reset
REQ-030 While rst_n=0 the module SHALL hold state FETCH, PC=RESET_PC, instr=0, instr_pc=0, misalign_err=0, retire_count=0.
REQ-031 imem_req_valid SHALL be 0 while rst_n=0 and SHALL rise on the first clock edge after deassertion.
REQ-032 Reset asserted mid-transaction SHALL abandon it; a late response arriving in FETCH SHALL be discarded.

Structure
REQ-033 Branch-op encodings, state encodings and the instruction width SHALL live in a shared package used by this block and the branch-select translator.
REQ-034 The taken decision SHALL be one combinational sub-module, branch_taken_eval (branch_op, alu_zero -> taken).

Verification
REQ-035 Reset RESET_PC=0x100, ready=1, rsp after 1 cycle, op=00 each resolve -> imem_addr sequence 0x100, 0x104, 0x108; retire_count=3.
REQ-036 op=10, alu_zero=1, target=0x200 -> next imem_addr=0x200; op=10, alu_zero=0 -> PC+4.
REQ-037 op=11, target=0x301 -> next imem_addr=0x300; op=11, target=0x302 -> misalign_err=1, HALT, no further requests.
REQ-038 imem_req_ready low 3 cycles, instr_ready low 2 cycles -> imem_addr, instr, instr_pc stable; no duplicate requests.
REQ-039 PC=0xFFFF_FFFC, op=00 -> next imem_addr=0x0000_0000.
REQ-040 rst_n pulsed low during WAIT, then a stale rsp arrives in FETCH -> rsp ignored, instr_valid stays 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the fetch unit and the branch-select translator.
// Pure types/constants: no latency, no backpressure.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        BR_NEVER  = 2'b00,
        BR_IF_NZ  = 2'b01,
        BR_IF_Z   = 2'b10,
        BR_ALWAYS = 2'b11
    } branch_op_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_HALT    = 3'd4
    } ifu_state_e;

    // Taken targets are halfword aligned: bit 0 of the ALU sum is dropped.
    function automatic logic [ADDR_W-1:0] taken_pc(input logic [ADDR_W-1:0] target);
        return target & ~ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of imem, decode and resolve signals around the fetch unit.
// Pure wiring: no latency; each group uses its own valid/ready or valid-only handshake.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               resolve_valid;
    logic [1:0]         branch_op;
    logic               alu_zero;
    logic [ADDR_W-1:0]  branch_target;
    logic               misalign_err;
    logic [31:0]        retire_count;

    modport master (
        output imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
               misalign_err, retire_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               resolve_valid, branch_op, alu_zero, branch_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
               misalign_err, retire_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               resolve_valid, branch_op, alu_zero, branch_target
    );

endinterface

// File: rtl/instr_fetch_unit_branch_taken_eval.sv
// Branch taken decision from branch_op and the ALU zero flag.
// Combinational, zero latency; no backpressure.
module branch_taken_eval
    import instr_fetch_unit_pkg::*;
(
    input  branch_op_e branch_op,
    input  logic       alu_zero,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_op)
            BR_NEVER:  taken = 1'b0;
            BR_IF_NZ:  taken = ~alu_zero;
            BR_IF_Z:   taken = alu_zero;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// One-instruction-in-flight fetch loop: request, capture, hand to decode, await resolve.
// Latency: 4 cycles accept-to-next-request; stalls in place on imem_req_ready/instr_ready low.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
);

    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        retire_q, retire_d;
    logic               req_vld_q, req_vld_d;
    logic               instr_vld_q, instr_vld_d;
    logic               taken;

    branch_taken_eval u_taken (
        .branch_op (branch_op_e'(bus.branch_op)),
        .alu_zero  (bus.alu_zero),
        .taken     (taken)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;
        retire_d   = retire_q;
        case (state_q)
            ST_FETCH: begin
                // Handshake uses the registered valid, so the first post-reset cycle cannot accept.
                if (req_vld_q && bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d    = bus.imem_rsp_data;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (bus.resolve_valid) begin
                    retire_d = retire_q + 32'd1;
                    if (taken && bus.branch_target[1]) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = taken ? taken_pc(bus.branch_target) : pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        req_vld_d   = (state_d == ST_FETCH);
        instr_vld_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            misalign_q  <= 1'b0;
            retire_q    <= '0;
            req_vld_q   <= 1'b0;
            instr_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            misalign_q  <= misalign_d;
            retire_q    <= retire_d;
            req_vld_q   <= req_vld_d;
            instr_vld_q <= instr_vld_d;
        end
    end

    assign bus.imem_req_valid = req_vld_q;
    assign bus.imem_addr      = pc_q;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.instr_valid    = instr_vld_q;
    assign bus.misalign_err   = misalign_q;
    assign bus.retire_count   = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC = 0x100.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   acc    = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Accepted-request counter, used to detect duplicate or post-halt requests.
    always @(posedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) acc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one minimum-latency loop from FETCH (valid already high) through resolve.
    task automatic run_txn(input logic [31:0] data, input logic [31:0] exp_pc,
                           input logic [1:0] op, input logic zero, input logic [31:0] tgt);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("hold_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_instr", bus.instr, data);
        chk("hold_instr_pc", bus.instr_pc, exp_pc);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("resolve_instr_valid", 32'(bus.instr_valid), 32'd0);
        bus.resolve_valid = 1'b1;
        bus.branch_op     = op;
        bus.alu_zero      = zero;
        bus.branch_target = tgt;
        tick();
        bus.resolve_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_snap;
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.branch_op      = 2'b00;
        bus.alu_zero       = 1'b0;
        bus.branch_target  = '0;

        repeat (2) tick();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h100);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        chk("rst_retire", bus.retire_count, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);

        // Sequential fetch with op=00.
        run_txn(32'hA000_0001, 32'h100, 2'b00, 1'b0, 32'h0);
        chk("seq_addr1", bus.imem_addr, 32'h104);
        chk("seq_req_valid", 32'(bus.imem_req_valid), 32'd1);
        run_txn(32'hA000_0002, 32'h104, 2'b00, 1'b1, 32'h900);
        chk("seq_addr2", bus.imem_addr, 32'h108);
        run_txn(32'hA000_0003, 32'h108, 2'b00, 1'b0, 32'h0);
        chk("seq_addr3", bus.imem_addr, 32'h10C);
        chk("seq_retire3", bus.retire_count, 32'd3);

        // Conditional branches.
        run_txn(32'hB000_0001, 32'h10C, 2'b10, 1'b1, 32'h200);
        chk("bz_taken_addr", bus.imem_addr, 32'h200);
        run_txn(32'hB000_0002, 32'h200, 2'b10, 1'b0, 32'h500);
        chk("bz_not_taken_addr", bus.imem_addr, 32'h204);
        run_txn(32'hB000_0003, 32'h204, 2'b01, 1'b0, 32'h400);
        chk("bnz_taken_addr", bus.imem_addr, 32'h400);
        run_txn(32'hB000_0004, 32'h400, 2'b01, 1'b1, 32'h600);
        chk("bnz_not_taken_addr", bus.imem_addr, 32'h404);
        run_txn(32'hB000_0005, 32'h404, 2'b11, 1'b0, 32'h301);
        chk("always_odd_addr", bus.imem_addr, 32'h300);
        chk("retire8", bus.retire_count, 32'd8);

        // Stall on imem_req_ready for 3 cycles.
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("stall_addr", bus.imem_addr, 32'h300);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hC0DE_0300;
        tick();
        // Stray response and resolve while in HOLD must be ignored.
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        bus.resolve_valid  = 1'b1;
        bus.branch_op      = 2'b11;
        bus.branch_target  = 32'h800;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("hold_stall_instr", bus.instr, 32'hC0DE_0300);
            chk("hold_stall_pc", bus.instr_pc, 32'h300);
            chk("hold_stall_req", 32'(bus.imem_req_valid), 32'd0);
        end
        bus.imem_rsp_valid = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.instr_ready    = 1'b1;
        tick();
        bus.instr_ready    = 1'b0;
        chk("stall_retire_unchanged", bus.retire_count, 32'd8);
        bus.resolve_valid  = 1'b1;
        bus.branch_op      = 2'b11;
        bus.branch_target  = 32'hFFFF_FFFC;
        tick();
        bus.resolve_valid  = 1'b0;
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("retire9", bus.retire_count, 32'd9);
        chk("accepted9", 32'(acc), 32'd9);

        // PC wrap.
        run_txn(32'hD000_0001, 32'hFFFF_FFFC, 2'b00, 1'b0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("retire10", bus.retire_count, 32'd10);

        // Reset during WAIT, then a stale response arrives in FETCH.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("midrst_addr", bus.imem_addr, 32'h100);
        chk("midrst_retire", bus.retire_count, 32'd0);
        #2;
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h5A5A_5A5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stale_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("stale_instr_valid", 32'(bus.instr_valid), 32'd0);
            chk("stale_instr", bus.instr, 32'd0);
            chk("stale_addr", bus.imem_addr, 32'h100);
        end
        bus.imem_rsp_valid = 1'b0;

        // Misaligned taken target halts the loop.
        run_txn(32'hE000_0001, 32'h100, 2'b11, 1'b0, 32'h302);
        chk("halt_misalign", 32'(bus.misalign_err), 32'd1);
        chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("halt_addr", bus.imem_addr, 32'h100);
        chk("halt_retire", bus.retire_count, 32'd1);
        acc_snap = acc;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.resolve_valid  = 1'b1;
        bus.branch_op      = 2'b00;
        repeat (4) tick();
        chk("halt_no_requests", 32'(acc), 32'(acc_snap));
        chk("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_req_valid2", 32'(bus.imem_req_valid), 32'd0);
        chk("halt_misalign_sticky", 32'(bus.misalign_err), 32'd1);
        chk("halt_retire_frozen", bus.retire_count, 32'd1);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.resolve_valid  = 1'b0;

        // Only reset leaves HALT.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("unhalt_misalign", 32'(bus.misalign_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("unhalt_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("unhalt_addr", bus.imem_addr, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
